bus_slave_if: RTL and testbench

Slave-side responder for the CPU's request/grant/strobe/ready system bus. Sits between the bus interconnect and one on-chip synchronous device (RAM, peripheral register bank). It latches a single access strobe, drives the device through a fixed-latency strobe/wait sequence, and returns a one-cycle ready pulse with read data to the bus master.

---
 rtl/bus_slave_if_if.sv | 32 +++
 rtl/bus_slave_if.sv | 179 +++++++++++++++++
 tb/tb_bus_slave_if.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_slave_if_if.sv
`default_nettype none
//==============================================================================
// Module      : bus_slave_if_if
// Description : Request/strobe/ready system-bus bundle between the interconnect
//               (master side) and one bus_slave_if responder (slave side).
// Revision    : 1.0 - initial release
//==============================================================================
interface bus_slave_if_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              s_cs;
  logic              s_as;
  logic              s_rw;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wr_data;
  logic [DATA_W-1:0] s_rd_data;
  logic              s_rdy;
  logic              busy;
  logic              err;

  modport slave (
    input  s_cs, s_as, s_rw, s_addr, s_wr_data,
    output s_rd_data, s_rdy, busy, err
  );

  modport master (
    output s_cs, s_as, s_rw, s_addr, s_wr_data,
    input  s_rd_data, s_rdy, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/bus_slave_if.sv
`default_nettype none
//==============================================================================
// Module      : bus_slave_if
// Description : Slave-side responder for the request/strobe/ready system bus.
//               Accepts one access strobe, drives a synchronous device through
//               a fixed STROBE/WAIT sequence and returns a one-cycle ready
//               pulse (with read data on reads) to the bus master.
// Config      : BUS_SLAVE_RANGE_CHK_EN - when defined, offsets at or beyond
//               DEV_DEPTH complete immediately with zero data and set the
//               sticky err flag; when undefined, addresses alias modulo
//               2**DEV_ADDR_W and err is tied low.
// Revision    : 1.0 - initial release
//==============================================================================
module bus_slave_if #(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int DEV_ADDR_W  = 10,
  parameter int DEV_DEPTH   = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  bus_slave_if_if.slave              bus,
  output logic                       o_dev_cs,
  output logic                       o_dev_we,
  output logic [DEV_ADDR_W-1:0]      o_dev_addr,
  output logic [DATA_W-1:0]          o_dev_wr_data,
  input  wire logic [DATA_W-1:0]     i_dev_rd_data
);

  // Offset field below the interconnect's slave-select bits.
  localparam int         c_OFF_W       = 27;
  localparam logic [3:0] c_WAIT_CYCLES = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RDY    = 2'd3
  } state_t;

  state_t                r_state, w_state;
  logic [3:0]            r_cnt, w_cnt;
  logic                  r_dev_cs, w_dev_cs;
  logic                  r_dev_we, w_dev_we;
  logic [DEV_ADDR_W-1:0] r_dev_addr, w_dev_addr;
  logic [DATA_W-1:0]     r_dev_wr_data, w_dev_wr_data;
  logic [DATA_W-1:0]     r_rd_data, w_rd_data;
  logic                  r_rdy, w_rdy;
  logic                  r_busy, w_busy;
  logic                  w_accept;

  // Upper address bits are the interconnect's business; only the low bits
  // (and the offset, with range checking) are consumed here.
  wire w_unused_addr = ^bus.s_addr;

`ifdef BUS_SLAVE_RANGE_CHK_EN
  localparam logic [c_OFF_W-1:0] c_DEV_DEPTH = c_OFF_W'(DEV_DEPTH);
  logic r_err, w_err;
  logic w_out_of_range;
  assign w_out_of_range = (bus.s_addr[c_OFF_W-1:0] >= c_DEV_DEPTH);
`endif

  assign w_accept = bus.s_as & bus.s_cs;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_dev_cs      = 1'b0;
    w_dev_we      = r_dev_we;
    w_dev_addr    = r_dev_addr;
    w_dev_wr_data = r_dev_wr_data;
    w_rd_data     = r_rd_data;
    w_rdy         = 1'b0;
    w_busy        = r_busy;
`ifdef BUS_SLAVE_RANGE_CHK_EN
    w_err         = r_err;
`endif
    case (r_state)
      ST_IDLE: begin
        // Strobes without slave select belong to another slave.
        if (w_accept) begin
          w_busy = 1'b1;
`ifdef BUS_SLAVE_RANGE_CHK_EN
          if (w_out_of_range) begin
            // Complete at once with zero data; the device is never touched.
            w_state   = ST_RDY;
            w_rdy     = 1'b1;
            w_rd_data = '0;
            w_err     = 1'b1;
          end else
`endif
          begin
            w_state       = ST_STROBE;
            w_dev_cs      = 1'b1;
            w_dev_we      = bus.s_rw;
            w_dev_addr    = bus.s_addr[DEV_ADDR_W-1:0];
            w_dev_wr_data = bus.s_wr_data;
          end
        end
      end
      ST_STROBE: begin
        w_cnt   = c_WAIT_CYCLES;
        w_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt = r_cnt - 4'd1;
        end else begin
          // Writes return zero so the interconnect can OR all slaves.
          w_state   = ST_RDY;
          w_rdy     = 1'b1;
          w_rd_data = r_dev_we ? '0 : i_dev_rd_data;
        end
      end
      ST_RDY: begin
        w_state       = ST_IDLE;
        w_busy        = 1'b0;
        w_rd_data     = '0;
        w_dev_we      = 1'b0;
        w_dev_addr    = '0;
        w_dev_wr_data = '0;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access without a ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 4'd0;
      r_dev_cs      <= 1'b0;
      r_dev_we      <= 1'b0;
      r_dev_addr    <= '0;
      r_dev_wr_data <= '0;
      r_rd_data     <= '0;
      r_rdy         <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_dev_cs      <= w_dev_cs;
      r_dev_we      <= w_dev_we;
      r_dev_addr    <= w_dev_addr;
      r_dev_wr_data <= w_dev_wr_data;
      r_rd_data     <= w_rd_data;
      r_rdy         <= w_rdy;
      r_busy        <= w_busy;
    end
  end

`ifdef BUS_SLAVE_RANGE_CHK_EN
  // Sticky range-error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err;
    end
  end
  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.s_rd_data = r_rd_data;
  assign bus.s_rdy     = r_rdy;
  assign bus.busy      = r_busy;
  assign o_dev_cs      = r_dev_cs;
  assign o_dev_we      = r_dev_we;
  assign o_dev_addr    = r_dev_addr;
  assign o_dev_wr_data = r_dev_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_bus_slave_if.sv
`default_nettype none
//==============================================================================
// Module      : tb_bus_slave_if
// Description : Self-checking bench for bus_slave_if with a synchronous RAM
//               device model and a transaction-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_bus_slave_if;

  localparam int ADDR_W     = 30;
  localparam int DATA_W     = 32;
  localparam int DEV_ADDR_W = 10;
  localparam int DEV_DEPTH  = 1024;
  localparam int W          = 2;
  localparam int RDY_LAT    = 3 + W;
  localparam int WINDOW     = RDY_LAT + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_slave_if_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic                  dev_cs;
  logic                  dev_we;
  logic [DEV_ADDR_W-1:0] dev_addr;
  logic [DATA_W-1:0]     dev_wr_data;
  logic [DATA_W-1:0]     dev_rd_data;

  bus_slave_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEV_ADDR_W(DEV_ADDR_W),
    .DEV_DEPTH(DEV_DEPTH), .WAIT_CYCLES(W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .o_dev_cs(dev_cs), .o_dev_we(dev_we), .o_dev_addr(dev_addr),
    .o_dev_wr_data(dev_wr_data), .i_dev_rd_data(dev_rd_data)
  );

  // ---------------- synchronous RAM device ----------------
  logic [31:0] dev_mem [0:DEV_DEPTH-1];
  logic        mem_init = 1'b1;

  function automatic logic [31:0] init_word(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEV_DEPTH; i++) dev_mem[i] <= init_word(i);
      dev_rd_data <= '0;
    end else if (dev_cs) begin
      if (dev_we) dev_mem[dev_addr] <= dev_wr_data;
      else        dev_rd_data <= dev_mem[dev_addr];
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:DEV_DEPTH-1];
  logic        exp_err = 1'b0;

  typedef struct {
    int          rdy_cyc;
    int          cs_cnt;
    int          busy_cnt;
    logic [31:0] rdata;
  } exp_t;

  // One access: completion cycle, device strobes, busy length and data.
  task automatic predict(input logic rw, input logic [29:0] a,
                         input logic [31:0] wd, output exp_t e);
    bit oor = 1'b0;
`ifdef BUS_SLAVE_RANGE_CHK_EN
    oor = (a[26:0] >= 27'(DEV_DEPTH));
`endif
    if (oor) begin
      e.rdy_cyc = 1; e.cs_cnt = 0; e.busy_cnt = 1; e.rdata = 32'h0;
      exp_err = 1'b1;
    end else begin
      e.rdy_cyc = RDY_LAT; e.cs_cnt = 1; e.busy_cnt = RDY_LAT;
      e.rdata = rw ? 32'h0 : ref_mem[a[9:0]];
      if (rw) ref_mem[a[9:0]] = wd;
    end
  endtask

  int checks = 0;
  int errors = 0;

  // ---------------- access driver / observer ----------------
  int          o_rdy_cyc, o_rdy_cnt, o_cs_cyc, o_cs_cnt, o_stray;
  int          o_busy_cnt, o_busy_first, o_busy_last;
  logic [31:0] o_rdata, o_cs_wdata;
  logic [9:0]  o_cs_addr;
  logic        o_cs_we;

  task automatic bus_idle();
    bus.s_as = 1'b0; bus.s_cs = 1'b0; bus.s_rw = 1'b0;
    bus.s_addr = '0; bus.s_wr_data = '0;
  endtask

  // Cycle 0 is the strobe cycle; outputs are sampled on the falling edge.
  task automatic run_access(input logic rw, input logic [29:0] addr,
                            input logic [31:0] wd, input int extra_cyc);
    o_rdy_cyc = -1; o_rdy_cnt = 0; o_cs_cyc = -1; o_cs_cnt = 0; o_stray = 0;
    o_busy_cnt = 0; o_busy_first = -1; o_busy_last = -1;
    o_rdata = '0; o_cs_wdata = '0; o_cs_addr = '0; o_cs_we = 1'b0;
    @(posedge clk); #1;
    bus.s_as = 1'b1; bus.s_cs = 1'b1; bus.s_rw = rw;
    bus.s_addr = addr; bus.s_wr_data = wd;
    for (int c = 0; c < WINDOW; c++) begin
      @(negedge clk);
      if (dev_cs) begin
        o_cs_cnt++;
        if (o_cs_cnt == 1) begin
          o_cs_cyc = c; o_cs_we = dev_we; o_cs_addr = dev_addr; o_cs_wdata = dev_wr_data;
        end
      end
      if (bus.s_rdy) begin
        o_rdy_cnt++;
        if (o_rdy_cnt == 1) begin o_rdy_cyc = c; o_rdata = bus.s_rd_data; end
      end else if (bus.s_rd_data !== 32'h0) begin
        o_stray++;
      end
      if (bus.busy) begin
        o_busy_cnt++;
        if (o_busy_first < 0) o_busy_first = c;
        o_busy_last = c;
      end
      @(posedge clk); #1;
      bus.s_as = (c + 1 == extra_cyc);
    end
    bus_idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    checks++;
    if ({bus.s_rdy, bus.busy, bus.err, dev_cs, dev_we, dev_addr, dev_wr_data, bus.s_rd_data} !== '0) begin
      errors++; $display("FAIL reset_outputs: got busy=%b rdy=%b cs=%b addr=%0h, required all zero",
                         bus.busy, bus.s_rdy, dev_cs, dev_addr);
    end
    @(posedge clk); @(posedge clk); #1;
    mem_init = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_read_basic();
    exp_t e;
    predict(1'b0, 30'd5, 32'h0, e);
    run_access(1'b0, 30'd5, 32'h0, -1);
    checks++; if (o_cs_cnt !== 1 || o_cs_cyc !== 1) begin errors++;
      $display("FAIL read_dev_cs: got count=%0d first=%0d, required 1 at cycle 1", o_cs_cnt, o_cs_cyc); end
    checks++; if (o_cs_we !== 1'b0 || o_cs_addr !== 10'd5) begin errors++;
      $display("FAIL read_dev_addr: got we=%b addr=%0d, required we=0 addr=5", o_cs_we, o_cs_addr); end
    checks++; if (o_rdy_cyc !== e.rdy_cyc || o_rdy_cnt !== 1) begin errors++;
      $display("FAIL read_rdy_cycle: got %0d (count %0d), required %0d", o_rdy_cyc, o_rdy_cnt, e.rdy_cyc); end
    checks++; if (o_rdata !== 32'hDEADBEEF || o_rdata !== e.rdata) begin errors++;
      $display("FAIL read_data: got %08h, required %08h", o_rdata, e.rdata); end
    checks++; if (o_stray !== 0) begin errors++;
      $display("FAIL read_data_zero_outside_rdy: got %0d nonzero cycles, required 0", o_stray); end
    checks++; if (o_busy_first !== 1 || o_busy_last !== RDY_LAT || o_busy_cnt !== e.busy_cnt) begin errors++;
      $display("FAIL read_busy: got %0d..%0d (%0d), required 1..%0d", o_busy_first, o_busy_last, o_busy_cnt, RDY_LAT); end
  endtask

  task automatic test_write_readback();
    exp_t e;
    predict(1'b1, 30'd7, 32'h12345678, e);
    run_access(1'b1, 30'd7, 32'h12345678, -1);
    checks++; if (o_rdy_cyc !== e.rdy_cyc || o_rdy_cnt !== 1) begin errors++;
      $display("FAIL write_rdy_cycle: got %0d (count %0d), required %0d", o_rdy_cyc, o_rdy_cnt, e.rdy_cyc); end
    checks++; if (o_rdata !== 32'h0 || o_stray !== 0) begin errors++;
      $display("FAIL write_rd_data_zero: got %08h / %0d stray, required 0", o_rdata, o_stray); end
    checks++; if (o_cs_we !== 1'b1 || o_cs_addr !== 10'd7 || o_cs_wdata !== 32'h12345678) begin errors++;
      $display("FAIL write_dev_signals: got we=%b addr=%0d data=%08h, required 1/7/12345678",
               o_cs_we, o_cs_addr, o_cs_wdata); end
    predict(1'b0, 30'd7, 32'h0, e);
    run_access(1'b0, 30'd7, 32'h0, -1);
    checks++; if (o_rdy_cyc !== RDY_LAT) begin errors++;
      $display("FAIL readback_rdy_cycle: got %0d, required %0d", o_rdy_cyc, RDY_LAT); end
    checks++; if (o_rdata !== 32'h12345678 || o_rdata !== e.rdata) begin errors++;
      $display("FAIL readback_data: got %08h, required 12345678", o_rdata); end
  endtask

  task automatic test_ignored_strobes();
    exp_t e;
    int   cs_seen = 0, rdy_seen = 0, busy_seen = 0;
    @(posedge clk); #1;
    bus.s_as = 1'b1; bus.s_cs = 1'b0; bus.s_addr = 30'd3;
    @(posedge clk); #1;
    bus.s_as = 1'b0;
    for (int c = 0; c < WINDOW; c++) begin
      @(negedge clk);
      cs_seen += int'(dev_cs); rdy_seen += int'(bus.s_rdy); busy_seen += int'(bus.busy);
    end
    bus_idle();
    checks++; if (cs_seen + rdy_seen + busy_seen !== 0) begin errors++;
      $display("FAIL unselected_strobe: got cs=%0d rdy=%0d busy=%0d, required none", cs_seen, rdy_seen, busy_seen); end
    predict(1'b0, 30'd9, 32'h0, e);
    run_access(1'b0, 30'd9, 32'h0, 2);
    checks++; if (o_cs_cnt !== 1) begin errors++;
      $display("FAIL second_strobe_dev_cs: got %0d, required 1", o_cs_cnt); end
    checks++; if (o_rdy_cnt !== 1 || o_rdy_cyc !== e.rdy_cyc) begin errors++;
      $display("FAIL second_strobe_rdy: got count=%0d cycle=%0d, required 1 at %0d", o_rdy_cnt, o_rdy_cyc, e.rdy_cyc); end
    checks++; if (o_busy_cnt !== e.busy_cnt || o_busy_last !== RDY_LAT) begin errors++;
      $display("FAIL second_strobe_busy: got %0d cycles, required %0d", o_busy_cnt, e.busy_cnt); end
    checks++; if (o_rdata !== e.rdata) begin errors++;
      $display("FAIL second_strobe_data: got %08h, required %08h", o_rdata, e.rdata); end
  endtask

  task automatic test_range();
    exp_t e;
    predict(1'b0, 30'd1024, 32'h0, e);
    run_access(1'b0, 30'd1024, 32'h0, -1);
    checks++; if (o_rdy_cyc !== e.rdy_cyc) begin errors++;
      $display("FAIL range_rdy_cycle: got %0d, required %0d", o_rdy_cyc, e.rdy_cyc); end
    checks++; if (o_cs_cnt !== e.cs_cnt) begin errors++;
      $display("FAIL range_dev_cs: got %0d, required %0d", o_cs_cnt, e.cs_cnt); end
    checks++; if (o_rdata !== e.rdata) begin errors++;
      $display("FAIL range_data: got %08h, required %08h", o_rdata, e.rdata); end
    checks++; if (e.cs_cnt == 1 && o_cs_addr !== 10'd0) begin errors++;
      $display("FAIL range_alias_addr: got %0d, required 0", o_cs_addr); end
    checks++; if (bus.err !== exp_err) begin errors++;
      $display("FAIL range_err: got %b, required %b", bus.err, exp_err); end
    predict(1'b0, 30'd5, 32'h0, e);
    run_access(1'b0, 30'd5, 32'h0, -1);
    checks++; if (bus.err !== exp_err || o_rdata !== e.rdata) begin errors++;
      $display("FAIL range_err_sticky: got err=%b data=%08h, required err=%b data=%08h",
               bus.err, o_rdata, exp_err, e.rdata); end
  endtask

  task automatic test_reset_abort(input int at_cyc);
    exp_t e;
    int   rdy_seen = 0;
    @(posedge clk); #1;
    bus.s_as = 1'b1; bus.s_cs = 1'b1; bus.s_rw = 1'b0; bus.s_addr = 30'd11;
    @(posedge clk); #1;
    bus.s_as = 1'b0;
    repeat (at_cyc - 1) @(posedge clk);
    #3;
    checks++; if (bus.busy !== 1'b1 || dev_cs !== (at_cyc == 1)) begin errors++;
      $display("FAIL abort_pre_state_c%0d: got busy=%b cs=%b, required busy=1 cs=%b",
               at_cyc, bus.busy, dev_cs, at_cyc == 1); end
    rst = 1'b1;
    #1;
    checks++; if ({bus.s_rdy, bus.busy, bus.err, dev_cs, dev_we, dev_addr, dev_wr_data, bus.s_rd_data} !== '0) begin
      errors++; $display("FAIL abort_async_zero_c%0d: got busy=%b cs=%b err=%b, required all zero",
                         at_cyc, bus.busy, dev_cs, bus.err); end
    exp_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_idle();
    for (int c = 0; c < WINDOW; c++) begin
      @(negedge clk);
      rdy_seen += int'(bus.s_rdy);
    end
    checks++; if (rdy_seen !== 0) begin errors++;
      $display("FAIL abort_no_rdy_c%0d: got %0d ready pulses, required 0", at_cyc, rdy_seen); end
    predict(1'b0, 30'd11, 32'h0, e);
    run_access(1'b0, 30'd11, 32'h0, -1);
    checks++; if (o_rdy_cyc !== e.rdy_cyc || o_rdata !== e.rdata || o_cs_cnt !== 1) begin errors++;
      $display("FAIL abort_recover_c%0d: got cycle=%0d data=%08h, required cycle=%0d data=%08h",
               at_cyc, o_rdy_cyc, o_rdata, e.rdy_cyc, e.rdata); end
  endtask

  task automatic test_random(input int n);
    exp_t        e;
    logic [31:0] rnd;
    logic [29:0] a;
    logic [31:0] wd;
    logic        rw;
    for (int i = 0; i < n; i++) begin
      rnd = $urandom;
      a = rnd[29:0];
      if ($urandom_range(0, 3) != 0) a[26:10] = '0;
      a[9:0] = 10'($urandom_range(0, 15));
      rw = 1'($urandom_range(0, 1));
      wd = $urandom;
      predict(rw, a, wd, e);
      run_access(rw, a, wd, -1);
      checks++; if (o_rdy_cyc !== e.rdy_cyc || o_rdy_cnt !== 1) begin errors++;
        $display("FAIL rand%0d_rdy: got cycle=%0d count=%0d, required %0d", i, o_rdy_cyc, o_rdy_cnt, e.rdy_cyc); end
      checks++; if (o_rdata !== e.rdata || o_stray !== 0) begin errors++;
        $display("FAIL rand%0d_data: got %08h stray=%0d, required %08h", i, o_rdata, o_stray, e.rdata); end
      checks++; if (o_cs_cnt !== e.cs_cnt || o_busy_cnt !== e.busy_cnt) begin errors++;
        $display("FAIL rand%0d_cs_busy: got cs=%0d busy=%0d, required cs=%0d busy=%0d",
                 i, o_cs_cnt, o_busy_cnt, e.cs_cnt, e.busy_cnt); end
      if (e.cs_cnt == 1) begin
        checks++; if (o_cs_addr !== a[9:0] || o_cs_we !== rw || (rw && o_cs_wdata !== wd)) begin errors++;
          $display("FAIL rand%0d_dev: got addr=%0h we=%b data=%08h, required addr=%0h we=%b data=%08h",
                   i, o_cs_addr, o_cs_we, o_cs_wdata, a[9:0], rw, wd); end
      end
      checks++; if (bus.err !== exp_err) begin errors++;
        $display("FAIL rand%0d_err: got %b, required %b", i, bus.err, exp_err); end
    end
  endtask

  initial begin
    for (int i = 0; i < DEV_DEPTH; i++) ref_mem[i] = init_word(i);
    bus_idle();
    test_reset();
    test_read_basic();
    test_write_readback();
    test_ignored_strobes();
    test_range();
    test_reset_abort(1);
    test_reset_abort(3);
    test_random(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
